// File: rtl/wb_sched_if.sv
// ---------------------------------------------------------------------------
// wb_sched_if
//   Bundle of the writeback-stage signals exchanged between the pipeline and
//   the writeback scheduler.
//
//   master modport (pipeline / testbench side)
//     drives : wb_valid, wb_instr, pc_inc, alu_out, mem_out, mem_done
//     sees   : wb_ready, rf_wr_en, rf_wr_sel, rf_wr_data, pending_mask,
//              err, stall_cnt
//   slave modport (wb_sched side) is the mirror image.
//
//   DW and CNT_W must match the parameters of the wb_sched instance that
//   the interface is connected to.
// ---------------------------------------------------------------------------
interface wb_sched_if #(
    parameter int DW    = 16,
    parameter int CNT_W = 16
);
    logic             wb_valid;
    logic             wb_ready;
    logic [15:0]      wb_instr;
    logic [DW-1:0]    pc_inc;
    logic [DW-1:0]    alu_out;
    logic [DW-1:0]    mem_out;
    logic             mem_done;
    logic             rf_wr_en;
    logic [2:0]       rf_wr_sel;
    logic [DW-1:0]    rf_wr_data;
    logic [7:0]       pending_mask;
    logic             err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output wb_valid, wb_instr, pc_inc, alu_out, mem_out, mem_done,
        input  wb_ready, rf_wr_en, rf_wr_sel, rf_wr_data, pending_mask,
               err, stall_cnt
    );

    modport slave (
        input  wb_valid, wb_instr, pc_inc, alu_out, mem_out, mem_done,
        output wb_ready, rf_wr_en, rf_wr_sel, rf_wr_data, pending_mask,
               err, stall_cnt
    );
endinterface

// File: rtl/wb_sched.sv
// ---------------------------------------------------------------------------
// wb_sched
//   Writeback-stage scheduler for the 16-bit core. Classifies the instruction
//   sitting in WB, picks its destination register, holds WB on loads until
//   the multicycle data memory reports completion and then issues a single
//   register-file write. Exposes a one-hot mask of the register whose result
//   is held but not yet written, for hazard detection.
//
//   Ports
//     clk  : clock
//     rst  : synchronous reset, active-high
//     bus  : wb_sched_if.slave
//            wb_valid/wb_ready  WB handshake, transfer = valid & ready
//            wb_instr           instruction word
//            pc_inc, alu_out    link value and ALU result
//            mem_out, mem_done  load data and completion strobe
//            rf_wr_en/sel/data  register-file write port (sel/data 0 when idle)
//            pending_mask       one-hot of register with held result
//            err                sticky load-timeout flag
//            stall_cnt          saturating count of stalled valid cycles
//
//   Parameters
//     DW       datapath width
//     TIMEOUT  MEM_WAIT cycles allowed before a load is abandoned (>= 1)
//     CNT_W    stall counter width
// ---------------------------------------------------------------------------
module wb_sched #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic      clk,
    input  logic      rst,
    wb_sched_if.slave bus
);
    // Timer only has to reach TIMEOUT-1 (one count per MEM_WAIT cycle).
    localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        WRITE    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_ALU  = 2'd1,
        CLS_LOAD = 2'd2,
        CLS_LINK = 2'd3
    } cls_t;

    state_t        state, state_next;
    logic [TW-1:0] timer, timer_next;
    logic [2:0]    hold_sel, hold_sel_next;
    logic [DW-1:0] hold_data, hold_data_next;
    logic          err_q, err_set;
    logic [CNT_W-1:0] stall_q;

    logic [6:0]    op;
    cls_t          cls;
    logic [2:0]    dest;
    logic          ready;
    logic          accept;
    logic          wr_en;

    // Instruction class and destination register. Uses the same 7-bit
    // {instr[15:11], instr[1:0]} opcode as WB data selection so both
    // decoders agree; the low two bits happen not to matter for any class.
    always_comb begin
        op   = {bus.wb_instr[15:11], bus.wb_instr[1:0]};
        cls  = CLS_NONE;
        dest = 3'd0;
        casez (op)
            7'b11011??, 7'b11001??, 7'b111????: begin
                cls  = CLS_ALU;
                dest = bus.wb_instr[4:2];
            end
            7'b010????, 7'b101????: begin
                cls  = CLS_ALU;
                dest = bus.wb_instr[7:5];
            end
            7'b11000??, 7'b10010??: begin
                // LBI / SLBI write the register named in the Rs field
                cls  = CLS_ALU;
                dest = bus.wb_instr[10:8];
            end
            7'b10001??: begin
                cls  = CLS_LOAD;
                dest = bus.wb_instr[7:5];
            end
            7'b0011???: begin
                // JAL / JALR link into R7
                cls  = CLS_LINK;
                dest = 3'd7;
            end
            default: begin
                cls  = CLS_NONE;
                dest = 3'd0;
            end
        endcase
    end

    // Next-state and output logic. WRITE behaves like IDLE for accepting
    // a new instruction, which gives back-to-back one-write-per-cycle
    // throughput; the hold registers are reloaded at the same clock edge
    // that retires the current write.
    always_comb begin
        ready          = ~rst & (state != MEM_WAIT);
        accept         = bus.wb_valid & ready;

        state_next     = state;
        timer_next     = timer;
        hold_sel_next  = hold_sel;
        hold_data_next = hold_data;
        err_set        = 1'b0;

        case (state)
            IDLE, WRITE: begin
                state_next = IDLE;
                if (accept) begin
                    case (cls)
                        CLS_ALU: begin
                            hold_sel_next  = dest;
                            hold_data_next = bus.alu_out;
                            state_next     = WRITE;
                        end
                        CLS_LINK: begin
                            hold_sel_next  = dest;
                            hold_data_next = bus.pc_inc;
                            state_next     = WRITE;
                        end
                        CLS_LOAD: begin
                            hold_sel_next  = dest;
                            timer_next     = '0;
                            state_next     = MEM_WAIT;
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end
            MEM_WAIT: begin
                // A completion in the last allowed cycle still wins.
                if (bus.mem_done) begin
                    hold_data_next = bus.mem_out;
                    state_next     = WRITE;
                end else if (timer == TIMER_LAST) begin
                    err_set        = 1'b1;
                    timer_next     = '0;
                    state_next     = IDLE;
                end else begin
                    timer_next     = timer + TW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs are forced to their reset values while rst is high so a
        // held write never escapes in the reset cycle itself.
        wr_en            = ~rst & (state == WRITE);
        bus.wb_ready     = ready;
        bus.rf_wr_en     = wr_en;
        bus.rf_wr_sel    = wr_en ? hold_sel  : 3'd0;
        bus.rf_wr_data   = wr_en ? hold_data : '0;
        bus.pending_mask = (~rst && (state == MEM_WAIT || state == WRITE))
                           ? (8'h01 << hold_sel) : 8'h00;
        bus.err          = err_q;
        bus.stall_cnt    = stall_q;
    end

    // State, timer and holding registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            hold_sel  <= 3'd0;
            hold_data <= '0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            hold_sel  <= hold_sel_next;
            hold_data <= hold_data_next;
        end
    end

    // Sticky timeout flag and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            if (err_set) begin
                err_q <= 1'b1;
            end
            if (bus.wb_valid && !ready && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_sched.sv
// ---------------------------------------------------------------------------
// tb_wb_sched
//   Randomized scoreboard bench for wb_sched. The driver issues instructions
//   and memory responses and pushes every register-file write it expects into
//   a queue; an independent monitor pops that queue whenever the scheduler
//   strobes rf_wr_en. Expected writes, stall counts and the error flag come
//   from a reference model built from the instruction-class table.
// ---------------------------------------------------------------------------
module tb_wb_sched;
    localparam int DW      = 16;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 16;

    localparam int K_NONE = 0;
    localparam int K_ALU  = 1;
    localparam int K_LOAD = 2;
    localparam int K_LINK = 3;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] alu;
        logic [15:0] pc;
        logic [15:0] mem;
        int          lat;
        bit          hold;
        int          gap;
    } tx_t;

    typedef struct {
        logic [2:0]  sel;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;

    wb_sched_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

    wb_sched #(.DW(DW), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    wr_t expq[$];
    tx_t txs[$];
    int  compared   = 0;
    int  mismatched = 0;
    int  model_stall = 0;
    bit  model_err   = 1'b0;

    // One comparison; prints a FAIL line with actual and expected on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference classification, written straight from the class table on
    // the 5-bit major opcode.
    function automatic void refClassify(input logic [15:0] instr,
                                        output int kind, output logic [2:0] dest);
        logic [4:0] major;
        major = instr[15:11];
        kind  = K_NONE;
        dest  = 3'd0;
        if (major == 5'd27 || major == 5'd25 || major[4:2] == 3'b111) begin
            kind = K_ALU;  dest = instr[4:2];
        end else if (major[4:2] == 3'b010 || major[4:2] == 3'b101) begin
            kind = K_ALU;  dest = instr[7:5];
        end else if (major == 5'd24 || major == 5'd18) begin
            kind = K_ALU;  dest = instr[10:8];
        end else if (major == 5'd17) begin
            kind = K_LOAD; dest = instr[7:5];
        end else if (major[4:1] == 4'b0011) begin
            kind = K_LINK; dest = 3'd7;
        end
    endfunction

    function automatic tx_t mkTx(input logic [15:0] instr, input logic [15:0] alu,
                                 input logic [15:0] pc, input logic [15:0] mem,
                                 input int lat, input bit hold, input int gap);
        tx_t t;
        t.instr = instr; t.alu = alu; t.pc = pc; t.mem = mem;
        t.lat = lat; t.hold = hold; t.gap = gap;
        return t;
    endfunction

    function automatic tx_t randomTx();
        tx_t t;
        int  r;
        t.instr = 16'($urandom);
        r = int'($urandom_range(0, 9));
        if (r <= 2)      t.instr[15:11] = 5'b10001;
        else if (r == 3) t.instr[15:11] = {4'b0011, 1'($urandom_range(0, 1))};
        t.alu = 16'($urandom);
        t.pc  = 16'($urandom);
        t.mem = 16'($urandom);
        r = int'($urandom_range(0, 7));
        if (r == 0)      t.lat = TIMEOUT + 1;
        else if (r == 1) t.lat = TIMEOUT;
        else             t.lat = int'($urandom_range(1, 5));
        t.hold = bit'($urandom_range(0, 1));
        t.gap  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        return t;
    endfunction

    // Issue one instruction (entered and left just after a rising edge).
    // For loads, also plays the memory: mem_done in wait cycle t.lat, or
    // never if t.lat exceeds TIMEOUT. While the load waits, the following
    // instruction may already be presented to exercise the stall counter.
    task automatic applyStimulus(input tx_t t, input tx_t nxt, input bit has_next);
        int         kind;
        logic [2:0] dest;
        int         n;
        for (int g = 0; g < t.gap; g++) begin
            bus.wb_valid = 1'b0;
            bus.mem_done = 1'($urandom_range(0, 1));
            bus.mem_out  = 16'($urandom);
            @(negedge clk);
            @(posedge clk); #1;
        end
        bus.wb_valid = 1'b1;
        bus.wb_instr = t.instr;
        bus.alu_out  = t.alu;
        bus.pc_inc   = t.pc;
        bus.mem_done = 1'($urandom_range(0, 1));
        bus.mem_out  = 16'($urandom);
        @(negedge clk);
        checkOutput("ready_on_issue", 32'(bus.wb_ready), 32'd1);
        checkOutput("err", 32'(bus.err), 32'(model_err));
        checkOutput("stall_cnt", 32'(bus.stall_cnt), 32'(model_stall));
        refClassify(t.instr, kind, dest);
        @(posedge clk);
        if (kind == K_ALU)  expq.push_back('{dest, t.alu});
        if (kind == K_LINK) expq.push_back('{dest, t.pc});
        #1;
        if (kind == K_LOAD) begin
            n = (t.lat <= TIMEOUT) ? t.lat : TIMEOUT;
            for (int c = 1; c <= n; c++) begin
                bus.wb_valid = t.hold & has_next;
                bus.wb_instr = nxt.instr;
                bus.alu_out  = nxt.alu;
                bus.pc_inc   = nxt.pc;
                bus.mem_done = (c == t.lat);
                bus.mem_out  = (c == t.lat) ? t.mem : 16'($urandom);
                @(negedge clk);
                checkOutput("ready_in_wait", 32'(bus.wb_ready), 32'd0);
                checkOutput("pending_in_wait", 32'(bus.pending_mask), 32'(8'h01 << dest));
                if (bus.wb_valid && model_stall < (2 ** CNT_W) - 1) model_stall++;
                if (c == t.lat) expq.push_back('{dest, t.mem});
                @(posedge clk); #1;
            end
            if (t.lat > TIMEOUT) model_err = 1'b1;
        end
        bus.wb_valid = 1'b0;
        // a late completion after an abandoned load must be ignored
        bus.mem_done = (kind == K_LOAD && t.lat > TIMEOUT);
        bus.mem_out  = 16'($urandom);
    endtask

    // Load accepted, reset raised in its second MEM_WAIT cycle, then a
    // stale mem_done arrives and must not produce a write.
    task automatic applyResetInWait();
        bus.wb_valid = 1'b1;
        bus.wb_instr = 16'h88A0;
        bus.mem_done = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        bus.wb_valid = 1'b0;
        @(negedge clk);
        checkOutput("rstwait_pending", 32'(bus.pending_mask), 32'h20);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstwait_ready_in_rst", 32'(bus.wb_ready), 32'd0);
        checkOutput("rstwait_mask_in_rst", 32'(bus.pending_mask), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("rstwait_queue_empty", 32'(expq.size()), 32'd0);
        model_stall  = 0;
        model_err    = 1'b0;
        bus.mem_done = 1'b1;
        bus.mem_out  = 16'hDEAD;
        @(negedge clk);
        checkOutput("rstwait_err", 32'(bus.err), 32'd0);
        checkOutput("rstwait_stall", 32'(bus.stall_cnt), 32'd0);
        checkOutput("rstwait_mask", 32'(bus.pending_mask), 32'd0);
        checkOutput("rstwait_ready", 32'(bus.wb_ready), 32'd1);
        @(posedge clk); #1;
        bus.mem_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected
    // write; when no write is strobed, sel and data must read as zero.
    always @(negedge clk) begin
        wr_t e;
        if (bus.rf_wr_en === 1'b1) begin
            if (expq.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_write: got sel=%0d data=0x%0h, expected no write",
                         bus.rf_wr_sel, bus.rf_wr_data);
            end else begin
                e = expq.pop_front();
                checkOutput("wr_sel", 32'(bus.rf_wr_sel), 32'(e.sel));
                checkOutput("wr_data", 32'(bus.rf_wr_data), 32'(e.data));
                checkOutput("wr_pending", 32'(bus.pending_mask), 32'(8'h01 << e.sel));
            end
        end else begin
            checkOutput("idle_sel_data", {13'd0, bus.rf_wr_sel, bus.rf_wr_data}, 32'd0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not complete, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        bus.wb_valid = 1'b0;
        bus.wb_instr = 16'h0000;
        bus.alu_out  = '0;
        bus.pc_inc   = '0;
        bus.mem_out  = '0;
        bus.mem_done = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 32'(bus.wb_ready), 32'd0);
        checkOutput("rst_en", 32'(bus.rf_wr_en), 32'd0);
        checkOutput("rst_mask", 32'(bus.pending_mask), 32'd0);
        checkOutput("rst_err", 32'(bus.err), 32'd0);
        checkOutput("rst_stall", 32'(bus.stall_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed openers, then random traffic.
        txs.push_back(mkTx(16'hD94C, 16'h1234, 16'h0000, 16'h0000, 1, 1'b0, 0));
        txs.push_back(mkTx(16'h88A0, 16'h0000, 16'h0000, 16'hBEEF, 3, 1'b1, 0));
        txs.push_back(mkTx(16'h3000, 16'h0000, 16'h0042, 16'h0000, 1, 1'b0, 0));
        txs.push_back(mkTx(16'hD94C, 16'h5A5A, 16'h0000, 16'h0000, 1, 1'b0, 0));
        txs.push_back(mkTx(16'h88A0, 16'h0000, 16'h0000, 16'h1357, TIMEOUT, 1'b0, 0));
        txs.push_back(mkTx(16'h0800, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 1'b0, 0));
        for (int i = 0; i < 300; i++) txs.push_back(randomTx());
        for (int i = 0; i < txs.size(); i++) begin
            if (i + 1 < txs.size()) applyStimulus(txs[i], txs[i+1], 1'b1);
            else                    applyStimulus(txs[i], txs[i], 1'b0);
        end
        repeat (3) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        checkOutput("queue_drained_random", 32'(expq.size()), 32'd0);

        applyResetInWait();

        // Timeout with the next instruction waiting, then traffic continues
        // with err sticky; a completion in the last allowed cycle still writes.
        txs.delete();
        txs.push_back(mkTx(16'h88A0, 16'h0000, 16'h0000, 16'h0000, TIMEOUT + 1, 1'b1, 0));
        txs.push_back(mkTx(16'hD94C, 16'hC0DE, 16'h0000, 16'h0000, 1, 1'b0, 0));
        txs.push_back(mkTx(16'h0800, 16'h0000, 16'h0000, 16'h0000, 1, 1'b0, 0));
        txs.push_back(mkTx(16'h88A0, 16'h0000, 16'h0000, 16'h2468, TIMEOUT, 1'b0, 0));
        txs.push_back(mkTx(16'hC000, 16'h0077, 16'h0000, 16'h0000, 1, 1'b0, 0));
        for (int i = 0; i < txs.size(); i++) begin
            if (i + 1 < txs.size()) applyStimulus(txs[i], txs[i+1], 1'b1);
            else                    applyStimulus(txs[i], txs[i], 1'b0);
        end
        repeat (3) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput("final_err", 32'(bus.err), 32'(model_err));
        checkOutput("final_stall", 32'(bus.stall_cnt), 32'(model_stall));
        checkOutput("final_queue_drained", 32'(expq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
